// File: rtl/ifetch_dram_responder_pkg.sv
// ifetch_pkg: fill FSM states, default line geometry and the line-alignment helper.
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
    localparam int LINE_WORDS_DEF = 4;
    localparam int WORD_OFF_W = $clog2(LINE_WORDS_DEF);
    localparam int TAG_LSB = WORD_OFF_W + 2;
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int lsb = TAG_LSB);
        return addr & ~((64'd1 << lsb) - 64'd1);
    endfunction
endpackage

// File: rtl/ifetch_dram_responder_if.sv
// ifetch_dram_responder_if: multi-beat line read port between the responder and backing memory.
interface ifetch_dram_responder_if #(parameter int ADDR_W = 64);
    logic req;
    logic [ADDR_W-1:0] addr;
    logic ack;
    logic rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rvalid, rdata);
    modport slave (input req, addr, output ack, rvalid, rdata);
endinterface

// File: rtl/ifetch_dram_responder_line_buffer.sv
// ifetch_line_buffer: single instruction line with tag compare and word select.
module ifetch_line_buffer #(
    parameter int ADDR_W = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic lookup,
    input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0] tag,
    input  logic [$clog2(LINE_WORDS)-1:0] idx,
    input  logic clr,
    input  logic we,
    input  logic [$clog2(LINE_WORDS)-1:0] widx,
    input  logic [31:0] wdata,
    input  logic commit,
    input  logic commit_valid,
    input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0] commit_tag,
    output logic hit,
    output logic [31:0] word
);
    logic [31:0] words [LINE_WORDS];
    logic [ADDR_W-$clog2(LINE_WORDS)-3:0] line_tag;
    logic line_valid;
    always_ff @(posedge clk)
        if (we) words[widx] <= wdata;
    // a completing fill overrides a same-cycle clear; its validity already folds in invalidates
    always_ff @(posedge clk)
        if (reset) begin
            line_valid <= 1'b0;
            line_tag <= '0;
        end else begin
            line_valid <= commit ? commit_valid : clr ? 1'b0 : line_valid;
            line_tag <= commit ? commit_tag : line_tag;
        end
    assign hit = lookup && line_valid && tag == line_tag;
    assign word = words[idx];
endmodule

// File: rtl/ifetch_dram_responder.sv
// ifetch_dram_responder: serves DRAM-channel instruction fetches from a line buffer,
// refilling it from backing memory on a miss.
module ifetch_dram_responder
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int LINE_WORDS = 1 << WORD_OFF_W
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic inv,
    output logic [31:0] dram_dout,
    output logic dram_data_ready,
    ifetch_dram_responder_if.master mem
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_LO = OFF_W + 2;
    state_t state;
    logic inv_pending;
    logic [OFF_W-1:0] beat;
    logic hit;
    logic fill_beat;
    logic last_beat;
    logic [31:0] word;
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^fetch_addr[1:0];
    assign fill_beat = state == FILL && mem.rvalid;
    assign last_beat = fill_beat && beat == OFF_W'(LINE_WORDS - 1);
    assign dram_data_ready = hit;
    assign dram_dout = hit ? word : '0;
    // a miss in IDLE drops the old line so REQ/FILL never report hits
    ifetch_line_buffer #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) u_buf (
        .clk(clk),
        .reset(reset),
        .lookup(fetch_req),
        .tag(fetch_addr[ADDR_W-1:TAG_LO]),
        .idx(fetch_addr[TAG_LO-1:2]),
        .clr(state == IDLE && (inv || (fetch_req && !hit))),
        .we(fill_beat),
        .widx(beat),
        .wdata(mem.rdata),
        .commit(last_beat),
        .commit_valid(!(inv_pending || inv)),
        .commit_tag(mem.addr[ADDR_W-1:TAG_LO]),
        .hit(hit),
        .word(word)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            inv_pending <= 1'b0;
            beat <= '0;
            mem.req <= 1'b0;
            mem.addr <= '0;
        end else
            case (state)
                IDLE: if (fetch_req && !hit) begin
                    mem.addr <= ADDR_W'(line_base(64'(fetch_addr), TAG_LO));
                    mem.req <= 1'b1;
                    state <= REQ;
                end
                REQ: begin
                    inv_pending <= inv_pending || inv;
                    if (mem.ack) begin
                        mem.req <= 1'b0;
                        beat <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    inv_pending <= last_beat ? 1'b0 : inv_pending || inv;
                    beat <= fill_beat ? beat + 1'b1 : beat;
                    state <= last_beat ? IDLE : FILL;
                end
                default: state <= IDLE;
            endcase
    rvalid_only_in_fill: assert property (@(posedge clk) disable iff (reset) mem.rvalid |-> state == FILL);
endmodule

// File: tb/tb_ifetch_dram_responder.sv
// tb_ifetch_dram_responder: directed fetch/fill scenarios with an expected-word scoreboard.
module tb_ifetch_dram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fetch_req = 1'b0;
    logic inv = 1'b0;
    logic [63:0] fetch_addr = '0;
    logic [31:0] dram_dout;
    logic dram_data_ready;
    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int start = 0;
    logic [31:0] sb [$];

    ifetch_dram_responder_if #(.ADDR_W(64)) mem ();

    ifetch_dram_responder dut (
        .clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .inv(inv),
        .dram_dout(dram_dout),
        .dram_data_ready(dram_data_ready),
        .mem(mem)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [31:0] mword(input logic [63:0] a);
        if (a[63:4] != 60'h800_0000) return 32'hC000_0000 | a[31:0];
        case (a[3:2])
            2'd0: return 32'h11;
            2'd1: return 32'h22;
            2'd2: return 32'h33;
            default: return 32'h44;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_hit(input string tag);
        logic [31:0] e;
        e = sb.size() != 0 ? sb.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_ready"}, 64'(dram_data_ready), 64'd1);
        chk({tag, "_dout"}, 64'(dram_dout), 64'(e));
    endtask

    // entered in the first REQ cycle; acks after dly cycles, then streams nbeats back-to-back
    task automatic fill(input logic [63:0] base, input int dly, input int inv_at, input int nbeats);
        chk("req_raised", 64'(mem.req), 64'd1);
        chk("req_addr", mem.addr, base);
        repeat (dly) step();
        mem.ack = 1'b1;
        step();
        mem.ack = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            mem.rvalid = 1'b1;
            mem.rdata = mword(base + 64'(4 * i));
            inv = (i == inv_at);
            if (i == 0) begin
                settle();
                chk("req_dropped", 64'(mem.req), 64'd0);
            end
            step();
            inv = 1'b0;
            mem.rvalid = 1'b0;
        end
    endtask

    initial begin
        mem.ack = 1'b0;
        mem.rvalid = 1'b0;
        mem.rdata = '0;
        fetch_req = 1'b1;
        fetch_addr = 64'h8000_0000;
        step();
        step();
        chk("rst_req", 64'(mem.req), 64'd0);
        chk("rst_addr", mem.addr, 64'd0);
        chk("rst_ready", 64'(dram_data_ready), 64'd0);
        chk("rst_dout", 64'(dram_dout), 64'd0);

        reset = 1'b0;
        settle();
        chk("first_ready", 64'(dram_data_ready), 64'd0);
        step();
        chk("first_req", 64'(mem.req), 64'd1);
        chk("first_addr", mem.addr, 64'h8000_0000);
        reset = 1'b1;
        step();
        chk("rst_in_req", 64'(mem.req), 64'd0);

        reset = 1'b0;
        fetch_addr = 64'h8000_0004;
        sb.push_back(mword(fetch_addr));
        start = cyc_n;
        settle();
        chk("cold_ready", 64'(dram_data_ready), 64'd0);
        step();
        fill(64'h8000_0000, 3, -1, 4);
        settle();
        expect_hit("cold");
        chk("cold_latency", 64'(cyc_n - start), 64'd9);

        for (int i = 0; i < 4; i++) begin
            fetch_addr = 64'h8000_0000 + 64'(4 * i);
            sb.push_back(mword(fetch_addr));
            settle();
            expect_hit("sweep");
            chk("sweep_no_req", 64'(mem.req), 64'd0);
            step();
        end

        fetch_addr = 64'h8000_0008;
        inv = 1'b1;
        sb.push_back(mword(fetch_addr));
        settle();
        expect_hit("inv_same_cycle");
        step();
        inv = 1'b0;
        settle();
        chk("inv_cleared", 64'(dram_data_ready), 64'd0);
        step();
        fill(64'h8000_0000, 1, -1, 4);
        sb.push_back(mword(fetch_addr));
        settle();
        expect_hit("refill");

        fetch_addr = 64'h8000_0010;
        settle();
        chk("cross_ready", 64'(dram_data_ready), 64'd0);
        step();
        fill(64'h8000_0010, 1, -1, 4);
        sb.push_back(mword(fetch_addr));
        settle();
        expect_hit("cross");

        fetch_addr = 64'h8000_0000;
        settle();
        chk("old_replaced", 64'(dram_data_ready), 64'd0);
        step();
        fill(64'h8000_0000, 2, 1, 4);
        settle();
        chk("inv_discard", 64'(dram_data_ready), 64'd0);
        fetch_addr = 64'h8000_0004;
        step();
        chk("refetch_req", 64'(mem.req), 64'd1);
        chk("refetch_addr", mem.addr, 64'h8000_0000);

        fill(64'h8000_0000, 0, -1, 1);
        reset = 1'b1;
        step();
        chk("rst_fill_req", 64'(mem.req), 64'd0);
        chk("rst_fill_ready", 64'(dram_data_ready), 64'd0);
        reset = 1'b0;
        sb.push_back(mword(fetch_addr));
        start = cyc_n;
        settle();
        chk("fresh_ready", 64'(dram_data_ready), 64'd0);
        step();
        fill(64'h8000_0000, 3, -1, 4);
        settle();
        expect_hit("fresh");
        chk("fresh_latency", 64'(cyc_n - start), 64'd9);

        fetch_req = 1'b0;
        settle();
        chk("idle_ready", 64'(dram_data_ready), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
